mem_rd_check: RTL and testbench
===============================

MEM_RD_CHECK -- requirements
Module: mem_rd_check

Interface
REQ-001 Parameter ADDR_W, 16, address width of the memory being read.
REQ-002 Parameter DATA_W, 8, data width excluding the parity bit.
REQ-003 Parameter DEPTH, 4, result FIFO entries; a power of two, at least 2.
REQ-004 Port clk  in  1  single clock; all state updates on posedge clk.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port read  in  1  read strobe, sampled in parallel with the memory's read input.
REQ-007 Port address  in  ADDR_W  address, sampled in parallel with the memory's address input.
REQ-008 Port data_out  in  DATA_W+1  memory read data; {parity, data}, parity = XOR of data bits.
REQ-009 Port rsp_valid  out  1  FIFO head holds a result.
REQ-010 Port rsp_ready  in  1  consumer accepts the head.
REQ-011 Port rsp_addr  out  ADDR_W  address of the head result.
REQ-012 Port rsp_data  out  DATA_W  data bits of the head result (parity stripped).
REQ-013 Port rsp_err  out  1  head result failed the parity check.
REQ-014 Port err_count  out  16  total parity errors detected.
REQ-015 Port overflow  out  1  sticky flag: a result was dropped because the FIFO was full.

Function
REQ-016 A posedge with read=1 and rst=0 SHALL set pend=1 and capture the address into pend_addr; otherwise pend=0.
REQ-017 A posedge with pend=1 SHALL sample data_out; read data is valid one cycle after the read edge.
REQ-018 The parity check SHALL fail when data_out[DATA_W] != XOR of data_out[DATA_W-1:0], or when any bit of data_out is X/Z.
REQ-019 The posedge at which the check is made SHALL push {pend_addr, data bits, err} into the FIFO.
REQ-020 Pushed results SHALL be visible on rsp_* from the following cycle (total latency read edge to rsp_valid = 2 cycles).
REQ-021 A pop SHALL occur on a posedge with rsp_valid=1 and rsp_ready=1.
REQ-022 rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 FIFO ordering SHALL be strict first-in, first-out; the read and write pointers wrap modulo DEPTH.
REQ-024 A push and a pop in the same cycle SHALL both complete, including when the FIFO is full.
REQ-025 A push to a full FIFO without a simultaneous pop SHALL drop the result and set overflow=1 until reset.
REQ-026 The error count SHALL increment on every failed check, including dropped results.
REQ-027 The error count SHALL saturate at 16'hFFFF.
REQ-028 Back-to-back reads (read=1 on consecutive edges) SHALL produce one result per cycle with no bubbles.
REQ-029 read with rsp_ready=0 SHALL remain legal; there is no back-pressure toward the memory.

Reset
REQ-030 The following SHALL be cleared to 0 by rst=1 at posedge: pend, FIFO pointers, occupancy, rsp_valid, err_count and overflow.
REQ-031 rsp_addr, rsp_data and rsp_err SHALL read 0 while the FIFO is empty after reset.
REQ-032 rst during an in-flight read SHALL discard the pending result, and no push SHALL follow.
REQ-033 rst SHALL take priority over simultaneous read, push or pop.

Configuration
REQ-034 The feature macro SHALL be MEM_RD_CHECK_ERR_CNT_EN.
REQ-035 With MEM_RD_CHECK_ERR_CNT_EN defined, err_count SHALL behave per REQ-026 and REQ-027.
REQ-036 Without MEM_RD_CHECK_ERR_CNT_EN, err_count SHALL be constant 0 with no counter flops; rsp_err remains functional.

Verification
REQ-037 Single read: memory address 16'h0010 holds 9'h1_07, read at cycle 0, rsp_ready=1 -> at cycle 2, rsp_valid=1, rsp_addr=16'h0010, rsp_data=8'h07, rsp_err=0.
REQ-038 Bad parity: data_out=9'h0_01 returned -> rsp_err=1 and err_count goes from 0 to 1.
REQ-039 Back-pressure and order: rsp_ready=0, reads to addresses 1, 2, 3, 4 -> rsp_valid held; releasing ready pops 1, 2, 3, 4 in order; overflow=0.
REQ-040 Overflow: rsp_ready=0, 5 reads, DEPTH=4 -> the 5th result is dropped, overflow=1, FIFO holds addresses 1-4.
REQ-041 Full with simultaneous pop: full FIFO, read issued, rsp_ready=1 at push edge -> no drop, overflow stays 0.
REQ-042 Reset mid-flight: read at cycle 0, rst=1 at cycle 1 -> rsp_valid stays 0 and err_count=0 through cycle 4.

Source files
------------

// File: rtl/mem_rd_check.sv
// Checks parity on memory read data and queues {address, data, error} results in a FIFO.
// Optional parity-error counter enabled by defining MEM_RD_CHECK_ERR_CNT_EN.
module mem_rd_check #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W:0]   data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [15:0]       err_count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a result is transferred on any posedge where rsp_valid && rsp_ready;
  // the head stays stable otherwise. There is no back-pressure toward the memory.

  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic              r_fifo_err  [DEPTH];

  logic w_err;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Even parity over all bits is 0 for good data; an unknown bit makes the XOR unknown.
  assign w_err   = ((^data_out) !== 1'b0);
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = w_valid & rsp_ready;
  assign w_push  = r_pend & (~w_full | w_pop);
  assign w_drop  = r_pend & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_pend <= read;
      if (read) begin
        r_pend_addr <= address;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_pend_addr;
      r_fifo_data[r_wr_ptr] <= data_out[DATA_W-1:0];
      r_fifo_err[r_wr_ptr]  <= w_err;
    end
  end

  assign rsp_valid = w_valid;
  assign rsp_addr  = w_valid ? r_fifo_addr[r_rd_ptr] : '0;
  assign rsp_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign rsp_err   = w_valid ? r_fifo_err[r_rd_ptr]  : 1'b0;
  assign overflow  = r_overflow;

`ifdef MEM_RD_CHECK_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Counts every failed check, including results dropped on overflow; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (r_pend && w_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_rd_check.sv
// Bench for mem_rd_check: queue-based reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_mem_rd_check;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W:0]   data_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [15:0]       err_count;
  logic              overflow;

  int n_vec;
  int n_err;
  logic chk_en;

  mem_rd_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .read(read), .address(address), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_count(err_count), .overflow(overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DATA_W:0] mem [32];

  function automatic logic [DATA_W:0] good(input logic [DATA_W-1:0] d);
    return {^d, d};
  endfunction

  always begin
    logic            rd_s;
    logic [4:0]      a_s;
    @(posedge clk);
    rd_s = read;
    a_s  = address[4:0];
    #1;
    data_out = rd_s ? mem[a_s] : '0;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } res_t;

  res_t        m_q[$];
  logic        m_pend;
  logic [ADDR_W-1:0] m_pend_addr;
  int          m_errs;
  logic        m_ovf;

  initial begin
    m_pend = 1'b0; m_pend_addr = '0; m_errs = 0; m_ovf = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pend = 1'b0;
      m_errs = 0;
      m_ovf  = 1'b0;
    end else begin
      bit popped;
      popped = (m_q.size() > 0) && rsp_ready;
      if (popped) void'(m_q.pop_front());
      if (m_pend) begin
        res_t r;
        r.addr = m_pend_addr;
        r.data = data_out[DATA_W-1:0];
        r.err  = ($countones(data_out[DATA_W-1:0]) % 2 == 1) != data_out[DATA_W];
        if (r.err && m_errs < 65535) m_errs++;
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else m_ovf = 1'b1;
      end
      m_pend      = read;
      m_pend_addr = address;
    end
  end

  // ---------------- compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] exp_cnt;
`ifdef MEM_RD_CHECK_ERR_CNT_EN
      exp_cnt = 16'(m_errs);
`else
      exp_cnt = 16'h0;
`endif
      chk("model_valid", 32'(rsp_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("model_addr", 32'(rsp_addr), 32'(m_q[0].addr));
        chk("model_data", 32'(rsp_data), 32'(m_q[0].data));
        chk("model_err",  32'(rsp_err),  32'(m_q[0].err));
      end else begin
        chk("empty_zero", {rsp_addr, rsp_data, 7'd0, rsp_err}, 32'd0);
      end
      chk("model_errcnt", 32'(err_count), 32'(exp_cnt));
      chk("model_ovf",    32'(overflow),  32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; read = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    rsp_ready = 1'b0;
    for (int i = 1; i <= n; i++) begin
      read = 1'b1; address = 16'(i);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    read = 1'b0; address = '0; rsp_ready = 1'b0; data_out = '0; rst = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = good(8'(i * 37 + 5));
    mem[5'h10] = 9'h1_07;
    mem[5'h08] = 9'h0_01;

    do_reset();
    chk_en = 1'b1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // single read, two-cycle latency
    rsp_ready = 1'b1; read = 1'b1; address = 16'h0010;
    tick();
    read = 1'b0;
    chk("single_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_addr", 32'(rsp_addr), 32'h0010);
    chk("single_data", 32'(rsp_data), 32'h07);
    chk("single_err", 32'(rsp_err), 32'd0);
    tick();

    // bad parity
    read = 1'b1; address = 16'h0008;
    tick();
    read = 1'b0;
    tick();
    chk("bad_err", 32'(rsp_err), 32'd1);
`ifdef MEM_RD_CHECK_ERR_CNT_EN
    chk("bad_errcnt", 32'(err_count), 32'd1);
`endif
    tick();

    // back-pressure and ordering
    fill(4);
    read = 1'b0;
    tick(); tick();
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head", 32'(rsp_addr), 32'd1);
    chk("bp_ovf", 32'(overflow), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_order", 32'(rsp_addr), 32'(i));
      tick();
    end
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    // overflow: fifth result dropped
    fill(5);
    read = 1'b0;
    tick();
    chk("ovf_flag", 32'(overflow), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", 32'(rsp_addr), 32'(i));
      tick();
    end
    chk("ovf_drained", 32'(rsp_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // full FIFO with simultaneous pop at push edge
    do_reset();
    fill(5);
    read = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(rsp_addr), 32'd2);
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_order", 32'(rsp_addr), 32'(i));
      tick();
    end

    // reset during an in-flight bad-parity read
    do_reset();
    read = 1'b1; address = 16'h0008;
    tick();
    rst = 1'b1; read = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_errcnt", 32'(err_count), 32'd0);
      tick();
    end

    // back-to-back reads with intermittent ready
    for (int i = 0; i < 24; i++) begin
      read = (i % 5 != 4);
      address = 16'(i % 12);
      rsp_ready = (i % 3 != 0);
      tick();
    end
    read = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("final_drained", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
